// File: rtl/sata_link_arb_dev.sv
// Device-side SATA link-layer arbiter: decides which engine (write or read)
// owns the TX primitive stream, retries frames ended by R_ERR, schedules
// periodic ALIGN insertion and drives SYNC/ALIGN while no engine owns the line.
module sata_link_arb_dev #(
  parameter int unsigned ALIGN_PERIOD = 254,
  parameter int unsigned RETRY_MAX    = 3,
  parameter int unsigned BACKOFF      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phyrdy,
  input  logic [4:0]  rx_dat_type,
  input  logic        tx_frame_req,
  output logic        tx_frame_done,
  output logic        tx_frame_ok,
  output logic        tx_replay,
  output logic        wr_req,
  input  logic        wr_no_busy,
  input  logic        wr_cpl,
  output logic        rd_req,
  input  logic        rd_no_busy,
  output logic        roll_insert,
  input  logic [4:0]  wr_tx_dat_type,
  input  logic [31:0] wr_tx_dat,
  input  logic [3:0]  wr_tx_char,
  input  logic [4:0]  rd_tx_dat_type,
  input  logic [31:0] rd_tx_dat,
  input  logic [3:0]  rd_tx_char,
  output logic [4:0]  tx_dat_type,
  output logic [31:0] tx_dat,
  output logic [3:0]  tx_char
);

  // Primitive codes of the codebase's sata_p_t encoding used by this block
  localparam logic [4:0] P_SYNC  = 5'd1;
  localparam logic [4:0] P_ALIGN = 5'd2;
  localparam logic [4:0] P_X_RDY = 5'd3;
  localparam logic [4:0] P_R_OK  = 5'd6;
  localparam logic [4:0] P_R_ERR = 5'd7;

  localparam logic [31:0] SYNC_DW  = 32'hB5B5_957C;
  localparam logic [31:0] ALIGN_DW = 32'h7B4A_4ABC;

  localparam logic [9:0] ALIGN_LAST = 10'(ALIGN_PERIOD - 1);
  localparam logic [2:0] RETRY_LIM  = 3'(RETRY_MAX);
  localparam logic [7:0] BO_LAST    = 8'(BACKOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_DONE,
    S_BACKOFF,
    S_RD
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  retry_q, retry_d;
  logic        res_q, res_d;
  logic [7:0]  bo_cnt_q, bo_cnt_d;
  logic [9:0]  align_cnt_q, align_cnt_d;
  logic [1:0]  align_left_q, align_left_d;
  logic        roll_q, roll_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        replay_q, replay_d;

  // Completion strobe is implied by the WR_DONE state and not needed here
  logic unused_inputs;
  assign unused_inputs = wr_cpl;

  // Register bank: FSM state, retry bookkeeping, ALIGN scheduler, strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      retry_q      <= '0;
      res_q        <= 1'b0;
      bo_cnt_q     <= '0;
      align_cnt_q  <= '0;
      align_left_q <= '0;
      roll_q       <= 1'b0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      replay_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      res_q        <= res_d;
      bo_cnt_q     <= bo_cnt_d;
      align_cnt_q  <= align_cnt_d;
      align_left_q <= align_left_d;
      roll_q       <= roll_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
      replay_q     <= replay_d;
    end
  end

  // Arbitration FSM: line ownership, result latching, retry and backoff
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    res_d    = res_q;
    bo_cnt_d = bo_cnt_q;
    done_d   = 1'b0;
    ok_d     = 1'b0;
    replay_d = 1'b0;
    if (!phyrdy) begin
      // Link loss overrides every other event, including wr_no_busy
      state_d = S_IDLE;
      retry_d = '0;
      if (state_q inside {S_WR, S_WR_DONE, S_BACKOFF}) done_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_dat_type == P_X_RDY) begin
            state_d = S_RD;
          end else if (tx_frame_req) begin
            state_d = S_WR;
            res_d   = 1'b0;
          end
        end
        S_WR: begin
          if (rx_dat_type == P_R_OK)       res_d = 1'b1;
          else if (rx_dat_type == P_R_ERR) res_d = 1'b0;
          if (wr_no_busy) state_d = S_WR_DONE;
        end
        S_WR_DONE: begin
          state_d = S_IDLE;
          if (res_q) begin
            done_d  = 1'b1;
            ok_d    = 1'b1;
            retry_d = '0;
          end else if (retry_q < RETRY_LIM) begin
            retry_d  = retry_q + 3'd1;
            replay_d = 1'b1;
            bo_cnt_d = '0;
            state_d  = S_BACKOFF;
          end else begin
            done_d  = 1'b1;
            retry_d = '0;
          end
        end
        S_BACKOFF: begin
          if (rx_dat_type == P_X_RDY) begin
            state_d = S_RD;
          end else if (bo_cnt_q == BO_LAST) begin
            state_d = S_WR;
            res_d   = 1'b0;
          end else begin
            bo_cnt_d = bo_cnt_q + 8'd1;
          end
        end
        S_RD: begin
          if (rd_no_busy) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ALIGN scheduler: free-running period counter while the PHY is up
  always_comb begin
    align_cnt_d = align_cnt_q;
    roll_d      = 1'b0;
    if (!phyrdy) begin
      align_cnt_d = '0;
    end else if (align_cnt_q == ALIGN_LAST) begin
      align_cnt_d = '0;
      roll_d      = 1'b1;
    end else begin
      align_cnt_d = align_cnt_q + 10'd1;
    end
    if (roll_q)                 align_left_d = 2'd2;
    else if (align_left_q != '0) align_left_d = align_left_q - 2'd1;
    else                        align_left_d = '0;
  end

  // TX mux: engine outputs pass straight through; idle line shows SYNC/ALIGN
  always_comb begin
    tx_dat_type = P_SYNC;
    tx_dat      = SYNC_DW;
    tx_char     = 4'b1000;
    unique case (state_q)
      S_WR, S_WR_DONE: begin
        tx_dat_type = wr_tx_dat_type;
        tx_dat      = wr_tx_dat;
        tx_char     = wr_tx_char;
      end
      S_RD: begin
        tx_dat_type = rd_tx_dat_type;
        tx_dat      = rd_tx_dat;
        tx_char     = rd_tx_char;
      end
      default: begin
        if (align_left_q != '0) begin
          tx_dat_type = P_ALIGN;
          tx_dat      = ALIGN_DW;
        end
      end
    endcase
  end

  assign wr_req        = (state_q == S_WR);
  assign rd_req        = (state_q == S_RD);
  assign roll_insert   = roll_q;
  assign tx_frame_done = done_q;
  assign tx_frame_ok   = ok_q;
  assign tx_replay     = replay_q;

endmodule
